// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause/mtval/mcycle/minstret/mhartid.
// Latency: reads, illegal flag and trap/mret targets are combinational; writes, traps, mret land 1 cycle later.
// Backpressure: none; every access, trap and mret is accepted in the cycle it is presented.
// Ports: clk/rst; CSR access (i_csr_ren, i_csr_addr, i_csr_op, i_csr_wdata -> o_csr_rdata, o_csr_illegal);
//        trap/mret events (i_trap_*, i_mret, i_instr_retire -> o_trap_target, o_mret_target);
//        o_mstatus .. o_minstret mirror the architectural registers for difftest.
module csr_unit #(
  parameter int              XLEN         = 64,
  parameter int              HAS_MINSTRET = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_csr_ren,
  input  logic [11:0]     i_csr_addr,
  input  logic [1:0]      i_csr_op,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret,
  input  logic            i_instr_retire,
  output logic [XLEN-1:0] o_trap_target,
  output logic [XLEN-1:0] o_mret_target,
  output logic [XLEN-1:0] o_mstatus,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mtval,
  output logic [XLEN-1:0] o_mscratch,
  output logic [XLEN-1:0] o_mcycle,
  output logic [XLEN-1:0] o_minstret
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] ONE    = XLEN'(1);
  localparam logic [XLEN-1:0] ALIGN2 = ~XLEN'(1);
  localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);

  // Only MIE/MPIE are stored; MPP is hardwired to M-mode.
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;

  logic [XLEN-1:0] mstatus_val, old_val, new_val;
  logic            mapped, access, illegal_raw, wr_en;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
  end

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (i_csr_addr)
      A_MSTATUS:  old_val = mstatus_val;
      A_MTVEC:    old_val = mtvec;
      A_MSCRATCH: old_val = mscratch;
      A_MEPC:     old_val = mepc;
      A_MCAUSE:   old_val = mcause;
      A_MTVAL:    old_val = mtval;
      A_MCYCLE:   old_val = mcycle;
      A_MINSTRET: old_val = minstret;
      A_MHARTID:  old_val = '0;
      default:    mapped  = 1'b0;
    endcase
  end

  always_comb begin
    access      = i_csr_ren | (i_csr_op != 2'b00);
    illegal_raw = access & (~mapped
                            | ((i_csr_addr == A_MHARTID) & (i_csr_op != 2'b00))
                            | ((i_csr_addr == A_MINSTRET) & (HAS_MINSTRET == 0)));
    wr_en       = (i_csr_op != 2'b00) & ~illegal_raw;
    // Reset masks both flags so nothing downstream acts on a stale decode.
    o_csr_illegal = ~rst & illegal_raw;
    o_csr_rdata   = (~rst & i_csr_ren & ~illegal_raw) ? old_val : '0;
    case (i_csr_op)
      2'b01:   new_val = i_csr_wdata;
      2'b10:   new_val = old_val | i_csr_wdata;
      2'b11:   new_val = old_val & ~i_csr_wdata;
      default: new_val = old_val;
    endcase
  end

  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval, wr_mcycle, wr_minstret;
  assign wr_mstatus  = wr_en & (i_csr_addr == A_MSTATUS);
  assign wr_mtvec    = wr_en & (i_csr_addr == A_MTVEC);
  assign wr_mscratch = wr_en & (i_csr_addr == A_MSCRATCH);
  assign wr_mepc     = wr_en & (i_csr_addr == A_MEPC);
  assign wr_mcause   = wr_en & (i_csr_addr == A_MCAUSE);
  assign wr_mtval    = wr_en & (i_csr_addr == A_MTVAL);
  assign wr_mcycle   = wr_en & (i_csr_addr == A_MCYCLE);
  assign wr_minstret = wr_en & (i_csr_addr == A_MINSTRET);

  // Trap beats mret beats CSR write, but only on registers the winner touches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN4;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
    end else begin
      if (i_trap_valid) begin
        mpie <= mie;
        mie  <= 1'b0;
      end else if (i_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mie  <= new_val[3];
        mpie <= new_val[7];
      end

      if (i_trap_valid)   mepc <= i_trap_pc & ALIGN2;
      else if (wr_mepc)   mepc <= new_val & ALIGN2;

      if (i_trap_valid)   mcause <= i_trap_cause;
      else if (wr_mcause) mcause <= new_val;

      if (i_trap_valid)   mtval <= i_trap_tval;
      else if (wr_mtval)  mtval <= new_val;

      if (wr_mtvec)       mtvec    <= new_val & ALIGN4;
      if (wr_mscratch)    mscratch <= new_val;

      mcycle <= wr_mcycle ? new_val : mcycle + ONE;
    end
  end

  generate
    if (HAS_MINSTRET != 0) begin : g_minstret
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 minstret <= '0;
        else if (wr_minstret)    minstret <= new_val;
        else if (i_instr_retire) minstret <= minstret + ONE;
      end
    end else begin : g_no_minstret
      assign minstret = '0;
    end
  endgenerate

  assign o_trap_target = mtvec & ALIGN4;
  assign o_mret_target = mepc;
  assign o_mstatus     = mstatus_val;
  assign o_mtvec       = mtvec;
  assign o_mepc        = mepc;
  assign o_mcause      = mcause;
  assign o_mtval       = mtval;
  assign o_mscratch    = mscratch;
  assign o_mcycle      = mcycle;
  assign o_minstret    = minstret;

endmodule

// File: tb/tb_csr_unit.sv
// Testbench for csr_unit: directed steps, expected values queued at drive time and checked on output.
// Latency: register checks one edge after stimulus, combinational checks after a 1-time-unit settle.
// Backpressure: none.
module tb_csr_unit;
  localparam int          XLEN      = 64;
  localparam logic [63:0] MTVEC_RST = 64'h8000_0103;
  localparam logic [63:0] MTVEC_EXP = 64'h8000_0100;
  localparam logic [63:0] ONES      = '1;

  localparam int S_MSTATUS = 0, S_MTVEC = 1, S_MEPC = 2, S_MCAUSE = 3, S_MTVAL = 4,
                 S_MSCRATCH = 5, S_MCYCLE = 6, S_MINSTRET = 7, S_RDATA = 8, S_ILLEGAL = 9,
                 S_TTGT = 10, S_MTGT = 11, S_N_MINSTRET = 12, S_N_ILLEGAL = 13, S_N_RDATA = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            csr_ren;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata, trap_cause, trap_pc, trap_tval;
  logic            trap_valid, mret, instr_retire;

  logic [XLEN-1:0] rdata, trap_target, mret_target, mstatus, mtvec, mepc, mcause, mtval,
                   mscratch, mcycle, minstret;
  logic            illegal;
  logic [XLEN-1:0] n_rdata, n_trap_target, n_mret_target, n_mstatus, n_mtvec, n_mepc, n_mcause,
                   n_mtval, n_mscratch, n_mcycle, n_minstret;
  logic            n_illegal;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(XLEN), .HAS_MINSTRET(1), .MTVEC_RESET(MTVEC_RST)) u_dut (
    .clk(clk), .rst(rst), .i_csr_ren(csr_ren), .i_csr_addr(csr_addr), .i_csr_op(csr_op),
    .i_csr_wdata(csr_wdata), .o_csr_rdata(rdata), .o_csr_illegal(illegal),
    .i_trap_valid(trap_valid), .i_trap_cause(trap_cause), .i_trap_pc(trap_pc),
    .i_trap_tval(trap_tval), .i_mret(mret), .i_instr_retire(instr_retire),
    .o_trap_target(trap_target), .o_mret_target(mret_target), .o_mstatus(mstatus),
    .o_mtvec(mtvec), .o_mepc(mepc), .o_mcause(mcause), .o_mtval(mtval),
    .o_mscratch(mscratch), .o_mcycle(mcycle), .o_minstret(minstret)
  );

  // Same stimulus into a variant without minstret.
  csr_unit #(.XLEN(XLEN), .HAS_MINSTRET(0), .MTVEC_RESET(MTVEC_RST)) u_dut_nomi (
    .clk(clk), .rst(rst), .i_csr_ren(csr_ren), .i_csr_addr(csr_addr), .i_csr_op(csr_op),
    .i_csr_wdata(csr_wdata), .o_csr_rdata(n_rdata), .o_csr_illegal(n_illegal),
    .i_trap_valid(trap_valid), .i_trap_cause(trap_cause), .i_trap_pc(trap_pc),
    .i_trap_tval(trap_tval), .i_mret(mret), .i_instr_retire(instr_retire),
    .o_trap_target(n_trap_target), .o_mret_target(n_mret_target), .o_mstatus(n_mstatus),
    .o_mtvec(n_mtvec), .o_mepc(n_mepc), .o_mcause(n_mcause), .o_mtval(n_mtval),
    .o_mscratch(n_mscratch), .o_mcycle(n_mcycle), .o_minstret(n_minstret)
  );

  string       sb_tag[$];
  int          sb_sel[$];
  logic [63:0] sb_exp[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_MSTATUS:    return mstatus;
      S_MTVEC:      return mtvec;
      S_MEPC:       return mepc;
      S_MCAUSE:     return mcause;
      S_MTVAL:      return mtval;
      S_MSCRATCH:   return mscratch;
      S_MCYCLE:     return mcycle;
      S_MINSTRET:   return minstret;
      S_RDATA:      return rdata;
      S_ILLEGAL:    return {63'd0, illegal};
      S_TTGT:       return trap_target;
      S_MTGT:       return mret_target;
      S_N_MINSTRET: return n_minstret;
      S_N_ILLEGAL:  return {63'd0, n_illegal};
      S_N_RDATA:    return n_rdata;
      default:      return 'x;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] val);
    sb_tag.push_back(tag);
    sb_sel.push_back(sel);
    sb_exp.push_back(val);
  endtask

  task automatic drain();
    string       tag;
    int          sel;
    logic [63:0] exp_v, obs_v;
    while (sb_sel.size() > 0) begin
      tag   = sb_tag.pop_front();
      sel   = sb_sel.pop_front();
      exp_v = sb_exp.pop_front();
      obs_v = observe(sel);
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic idle();
    csr_ren = 1'b0; csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret = 1'b0; instr_retire = 1'b0;
  endtask

  task automatic csr(input logic ren, input logic [11:0] addr, input logic [1:0] op,
                     input logic [63:0] wd);
    csr_ren = ren; csr_addr = addr; csr_op = op; csr_wdata = wd;
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  // Check queued expectations just after the edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    // Reset state, with an access presented that must be masked.
    csr(1'b1, 12'h300, 2'b00, '0);
    expect_val("rst_mstatus", S_MSTATUS, 64'h1800);
    expect_val("rst_mtvec",   S_MTVEC,   MTVEC_EXP);
    expect_val("rst_mcycle",  S_MCYCLE,  64'd0);
    expect_val("rst_rdata",   S_RDATA,   64'd0);
    settle();
    csr(1'b1, 12'h123, 2'b00, '0);
    expect_val("rst_illegal", S_ILLEGAL, 64'd0);
    settle();
    // Trap and write across an edge while in reset are discarded.
    trap_valid = 1'b1; trap_pc = 64'h44; csr(1'b0, 12'h340, 2'b01, 64'h77);
    expect_val("rst_trap_mepc",  S_MEPC,     64'd0);
    expect_val("rst_wr_mscr",    S_MSCRATCH, 64'd0);
    expect_val("rst_mcycle_hold", S_MCYCLE,  64'd0);
    tick();
    rst = 1'b0;

    expect_val("mcycle_1", S_MCYCLE, 64'd1); tick();
    expect_val("mcycle_2", S_MCYCLE, 64'd2); tick();
    expect_val("mcycle_3", S_MCYCLE, 64'd3); tick();

    // Reads.
    csr(1'b1, 12'h300, 2'b00, '0);
    expect_val("rd_mstatus", S_RDATA, 64'h1800);
    expect_val("rd_mstatus_ok", S_ILLEGAL, 64'd0);
    settle();
    csr(1'b1, 12'hF14, 2'b00, '0);
    expect_val("rd_mhartid", S_RDATA, 64'd0);
    expect_val("rd_mhartid_ok", S_ILLEGAL, 64'd0);
    settle();

    // RS mstatus with read of the pre-write value.
    csr(1'b1, 12'h300, 2'b10, 64'h8);
    expect_val("rs_pre", S_RDATA, 64'h1800);
    settle();
    expect_val("rs_mstatus", S_MSTATUS, 64'h1808);
    tick();

    // Trap entry.
    trap_valid = 1'b1; trap_pc = 64'h8000_0006; trap_cause = 64'hB; trap_tval = 64'hDEAD;
    expect_val("trap_mstatus", S_MSTATUS, 64'h1880);
    expect_val("trap_mepc",    S_MEPC,    64'h8000_0006);
    expect_val("trap_mcause",  S_MCAUSE,  64'hB);
    expect_val("trap_mtval",   S_MTVAL,   64'hDEAD);
    expect_val("trap_mret_tgt", S_MTGT,   64'h8000_0006);
    expect_val("trap_tgt",     S_TTGT,    MTVEC_EXP);
    tick();

    mret = 1'b1;
    expect_val("mret_mstatus", S_MSTATUS, 64'h1888);
    tick();

    // Trap + mret + mepc write together: trap wins.
    trap_valid = 1'b1; trap_pc = 64'h101; trap_cause = 64'h2; mret = 1'b1;
    csr(1'b0, 12'h341, 2'b01, 64'h1234);
    expect_val("tie_mepc",    S_MEPC,    64'h100);
    expect_val("tie_mcause",  S_MCAUSE,  64'h2);
    expect_val("tie_mstatus", S_MSTATUS, 64'h1880);
    tick();

    // mret with an mscratch write that it does not conflict with.
    mret = 1'b1; csr(1'b0, 12'h340, 2'b01, 64'h55);
    expect_val("mret_mscr",    S_MSCRATCH, 64'h55);
    expect_val("mret_mst2",    S_MSTATUS,  64'h1888);
    expect_val("mret_mepc_kp", S_MEPC,     64'h100);
    tick();

    // mret with an mstatus write: the write is lost.
    mret = 1'b1; csr(1'b0, 12'h300, 2'b11, 64'h88);
    expect_val("mret_wr_lost", S_MSTATUS, 64'h1888);
    tick();

    // Write masks.
    csr(1'b0, 12'h305, 2'b01, 64'h2003);
    expect_val("mtvec_mask", S_MTVEC, 64'h2000);
    expect_val("mtvec_tgt",  S_TTGT,  64'h2000);
    tick();
    csr(1'b0, 12'h341, 2'b01, 64'h3);
    expect_val("mepc_mask", S_MEPC, 64'h2);
    tick();
    csr(1'b0, 12'h300, 2'b01, 64'h0);
    expect_val("mst_zero", S_MSTATUS, 64'h1800);
    tick();
    csr(1'b0, 12'h300, 2'b01, ONES);
    expect_val("mst_ones", S_MSTATUS, 64'h1888);
    tick();

    // mcycle wrap.
    csr(1'b0, 12'hB00, 2'b01, ONES);
    expect_val("mcycle_wr", S_MCYCLE, ONES);
    tick();
    expect_val("mcycle_wrap", S_MCYCLE, 64'd0);
    tick();

    // minstret write / increment / RC-beats-retire; variant stays 0.
    csr(1'b0, 12'hB02, 2'b01, 64'h10);
    expect_val("nomi_wr_ill", S_N_ILLEGAL, 64'd1);
    settle();
    expect_val("minstret_wr", S_MINSTRET, 64'h10);
    expect_val("nomi_zero",   S_N_MINSTRET, 64'd0);
    tick();
    instr_retire = 1'b1;
    expect_val("minstret_inc", S_MINSTRET, 64'h11);
    tick();
    instr_retire = 1'b1; csr(1'b0, 12'hB02, 2'b11, 64'h1);
    expect_val("minstret_rc", S_MINSTRET, 64'h10);
    expect_val("nomi_zero2",  S_N_MINSTRET, 64'd0);
    tick();

    // Illegal accesses.
    csr(1'b1, 12'h123, 2'b00, '0);
    expect_val("ill_rd",       S_ILLEGAL, 64'd1);
    expect_val("ill_rd_rdata", S_RDATA,   64'd0);
    settle();
    csr(1'b0, 12'h123, 2'b00, '0);
    expect_val("noacc_legal", S_ILLEGAL, 64'd0);
    settle();
    csr(1'b1, 12'hF14, 2'b01, ONES);
    expect_val("ill_hart",       S_ILLEGAL, 64'd1);
    expect_val("ill_hart_rdata", S_RDATA,   64'd0);
    settle();
    expect_val("ill_keep_mst",  S_MSTATUS,  64'h1888);
    expect_val("ill_keep_mscr", S_MSCRATCH, 64'h55);
    tick();
    csr(1'b0, 12'h123, 2'b01, ONES);
    expect_val("ill_wr", S_ILLEGAL, 64'd1);
    settle();
    expect_val("ill_keep_mepc",  S_MEPC,  64'h2);
    expect_val("ill_keep_mtvec", S_MTVEC, 64'h2000);
    tick();
    csr(1'b1, 12'hB02, 2'b00, '0);
    expect_val("nomi_rd_ill",   S_N_ILLEGAL, 64'd1);
    expect_val("nomi_rd_rdata", S_N_RDATA,   64'd0);
    expect_val("mi_rd_legal",   S_ILLEGAL,   64'd0);
    expect_val("mi_rd_rdata",   S_RDATA,     64'h10);
    settle();
    idle();

    // Reset asserted between edges while a write is pending.
    csr(1'b1, 12'h340, 2'b01, 64'hAA);
    #2;
    rst = 1'b1;
    expect_val("arst_mscr",    S_MSCRATCH, 64'd0);
    expect_val("arst_mstatus", S_MSTATUS,  64'h1800);
    expect_val("arst_mtvec",   S_MTVEC,    MTVEC_EXP);
    expect_val("arst_mepc",    S_MEPC,     64'd0);
    expect_val("arst_mcycle",  S_MCYCLE,   64'd0);
    expect_val("arst_minst",   S_MINSTRET, 64'd0);
    expect_val("arst_rdata",   S_RDATA,    64'd0);
    settle();
    expect_val("arst_hold_mscr", S_MSCRATCH, 64'd0);
    tick();
    rst = 1'b0;
    expect_val("post_mcycle_1", S_MCYCLE, 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning CSR and data width; the only legal values are 32 and 64.
REQ-002 SHALL have parameter HAS_MINSTRET, default 1, meaning the minstret counter is implemented when the value is 1.
REQ-003 SHALL have parameter MTVEC_RESET, default 0, meaning the reset value of mtvec.
REQ-004 Ports, as name / direction / width / meaning:
  clk  in  1  the single clock; all state updates on its rising edge.
  rst  in  1  asynchronous, active-high reset.
  i_csr_ren  in  1  CSR read enable.
  i_csr_addr  in  12  CSR address.
  i_csr_op  in  2  CSR operation: 00 none, 01 RW, 10 RS, 11 RC.
  i_csr_wdata  in  XLEN  CSR write operand.
  o_csr_rdata  out  XLEN  CSR read data (combinational).
  o_csr_illegal  out  1  illegal CSR access flag (combinational).
  i_trap_valid  in  1  trap entry request.
  i_trap_cause  in  XLEN  trap cause, written to mcause.
  i_trap_pc  in  XLEN  trapping PC, written to mepc.
  i_trap_tval  in  XLEN  trap value, written to mtval.
  i_mret  in  1  mret execution.
  i_instr_retire  in  1  one instruction retired this cycle.
  o_trap_target  out  XLEN  current mtvec with bits[1:0] = 0.
  o_mret_target  out  XLEN  current mepc.
  o_mstatus, o_mtvec, o_mepc, o_mcause, o_mtval, o_mscratch, o_mcycle, o_minstret  out  XLEN each  difftest mirrors of those registers.

Function
REQ-005 SHALL decode these addresses: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
REQ-006 mhartid SHALL read as 0 and SHALL be read-only.
REQ-007 o_csr_illegal SHALL be 1 in any of these cases; otherwise it SHALL be 0:
  - (i_csr_ren or i_csr_op != 00) with an unmapped address;
  - i_csr_op != 00 targeting mhartid;
  - access to minstret when HAS_MINSTRET = 0.
REQ-008 o_csr_rdata SHALL equal the pre-write value of the addressed CSR when i_csr_ren = 1 and the access is legal; otherwise it SHALL be 0.
REQ-009 The new value of the addressed CSR on the clock edge SHALL be:
  - RW: wdata;
  - RS: old | wdata;
  - RC: old & ~wdata.
REQ-010 An illegal access SHALL change no state.
REQ-011 Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11 at all times; all other bits read 0.
  - mtvec: bits[1:0] are forced to 0 (direct mode only).
  - mepc: bit[0] is forced to 0.
REQ-012 On i_trap_valid at a clock edge:
  - mepc <= i_trap_pc with bit 0 cleared;
  - mcause <= i_trap_cause;
  - mtval <= i_trap_tval;
  - MPIE <= MIE, MIE <= 0.
REQ-013 On i_mret with no trap in the same cycle: MIE <= MPIE and MPIE <= 1.
REQ-014 Priority for the same cycle SHALL be trap > mret > CSR write; a CSR write that loses to a trap or mret is discarded for every register the trap or mret updates.
REQ-015 A CSR write to a register the winning event does not touch (for example mscratch) SHALL still take effect.
REQ-016 mcycle SHALL increment by 1 every cycle, modulo 2^XLEN; a legal write in a cycle replaces that cycle's increment.
REQ-017 minstret SHALL increment by 1 on i_instr_retire, modulo 2^XLEN; a legal write replaces that cycle's increment.
REQ-018 When HAS_MINSTRET = 0, minstret and o_minstret SHALL be constant 0.
REQ-019 o_trap_target and o_mret_target SHALL be combinational from current register state (zero added latency).
REQ-020 Every write, trap and mret effect SHALL be visible on the outputs the cycle after the clock edge (1-cycle latency).

Reset
REQ-021 While rst = 1, asynchronously and regardless of clk, the following SHALL hold:
  - mstatus = 0x1800;
  - mtvec = MTVEC_RESET with bits[1:0] = 0;
  - all other CSRs = 0.
REQ-022 While rst = 1, o_csr_rdata SHALL be 0 and o_csr_illegal SHALL be 0.
REQ-023 rst asserted in the same cycle as a trap, mret or write SHALL discard that trap, mret or write.
REQ-024 mcycle SHALL read 1 after the first clock edge following rst deassertion.

Verification
REQ-025 Reset then release with idle inputs -> o_mstatus = 0x1800, o_mtvec = MTVEC_RESET, o_mcycle = 0 during reset, then 1, 2, 3 on successive edges.
REQ-026 RS on mstatus with wdata 0x8, then a trap with pc 0x80000006 and cause 0xB -> o_mstatus = 0x1808, then 0x1880; o_mepc = 0x80000006; o_mcause = 0xB.
REQ-027 i_mret after REQ-026 -> o_mstatus = 0x1888.
REQ-028 Trap, mret and RW of mepc = 0x1234 in the same cycle -> trap wins; mepc = trap pc.
REQ-029 RW mcycle = all-ones -> o_mcycle = all-ones, then 0 on the next edge; RC of minstret while i_instr_retire = 1 -> the RC result is stored with no increment.
REQ-030 Read of 0x123, write to 0xF14, and access to minstret with HAS_MINSTRET = 0 -> o_csr_illegal = 1, o_csr_rdata = 0, all registers unchanged.
REQ-031 rst asserted mid-cycle between edges while a write is pending -> outputs return to reset values immediately, with no clk edge required.
